// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: BCD digit type, segment patterns and the digit decoder.
// Segment bit order is a..g in bits 0..6; the decimal point in bit 7 stays off.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg7_decode(input bcd_digit_t d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: 2-flop synchroniser, stability counter and a one-cycle pulse on the
// accepted 0->1 transition.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYC = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            pulse_q, pulse_d;

    // Level is accepted on the DEBOUNCE_CYC-th consecutive cycle it differs from acc_q.
    always_comb begin
        cnt_d = '0;
        acc_d = acc_q;
        if (sync_q[1] != acc_q) begin
            if (cnt_q == CntMax) begin
                acc_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = acc_d & ~acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/bcd_press_counter_disp.sv
// Push-button BCD up/down counter with a time-multiplexed 7-segment display driver and
// optional leading-zero blanking.
module bcd_press_counter_disp
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter int unsigned SCAN_DIV     = 70000,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_up,
    input  logic                    btn_dn,
    input  logic                    btn_clr,
    output logic [4*N_DIGITS-1:0]   bcd_out,
    output logic [7:0]              seg7,
    output logic [N_DIGITS-1:0]     seg7_sel
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(N_DIGITS - 1);

    logic up_pulse, dn_pulse, clr_pulse;

    btn_debounce_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_up),
        .pulse_o(up_pulse)
    );

    btn_debounce_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_dn),
        .pulse_o(dn_pulse)
    );

    btn_debounce_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_clr),
        .pulse_o(clr_pulse)
    );

    bcd_digit_t [N_DIGITS-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
    logic                      carry, borrow;

    // Digit-wise ripple carry/borrow keeps every digit in 0..9 without any division.
    always_comb begin
        cnt_inc = cnt_q;
        cnt_dec = cnt_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                cnt_inc[i] = (cnt_q[i] == 4'd9) ? 4'd0 : cnt_q[i] + 4'd1;
            end
            if (borrow) begin
                cnt_dec[i] = (cnt_q[i] == 4'd0) ? 4'd9 : cnt_q[i] - 4'd1;
            end
            carry  = carry & (cnt_q[i] == 4'd9);
            borrow = borrow & (cnt_q[i] == 4'd0);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_pulse) begin
            cnt_d = '0;
        end else if (up_pulse && !dn_pulse) begin
            cnt_d = cnt_inc;
        end else if (dn_pulse && !up_pulse) begin
            cnt_d = cnt_dec;
        end
    end

    logic [DivW-1:0]     div_q, div_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [N_DIGITS-1:0] lz;
    logic                zero_above;
    logic                tick;

    // lz[i]: digits i..N_DIGITS-1 are all zero; digit 0 is never flagged.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (cnt_q[i] == 4'd0);
            lz[i]      = zero_above;
        end
    end

    always_comb begin
        tick  = (div_q == DivMax);
        div_d = tick ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        seg_d = seg_q;
        sel_d = sel_q;
        if (tick) begin
            idx_d        = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
            sel_d        = '0;
            sel_d[idx_q] = 1'b1;
            seg_d        = (BLANK_LZ && lz[idx_q]) ? SEG_BLANK : seg7_decode(cnt_q[idx_q]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign bcd_out  = cnt_q;
    assign seg7     = seg_q;
    assign seg7_sel = sel_q;

endmodule
